// File: rtl/alu_arb_pkg.sv
// Shared constants for the alu_arbiter slice: opcode encodings, default widths, alu latency.
// Optional registered-response build is selected with ALU_ARB_RSP_REG_EN (see alu_arbiter).
package alu_arb_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_SEL_WIDTH  = 2;
  localparam int DEF_TAG_DEPTH  = 4;
  localparam int ALU_LATENCY    = 2;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_INC  = 2'b10,
    OP_ZERO = 2'b11
  } alu_op_e;

  // Width of a requester index; never collapses to zero bits.
  function automatic int tag_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_arb_tag_fifo.sv
// Synchronous FIFO of requester IDs for results still inside the alu.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module alu_arb_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 2-cycle alu among NUM_REQ requesters, routing results back by tag.
// Define ALU_ARB_RSP_REG_EN to register rsp_valid_o/rsp_data_o (adds one cycle of latency).
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SEL_WIDTH  = DEF_SEL_WIDTH,
  parameter int TAG_DEPTH  = DEF_TAG_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_1_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_2_i,
  input  logic [NUM_REQ*SEL_WIDTH-1:0]  req_sel_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          alu_valid_o,
  output logic [DATA_WIDTH-1:0]         alu_data_1_o,
  output logic [DATA_WIDTH-1:0]         alu_data_2_o,
  output logic [SEL_WIDTH-1:0]          alu_sel_o,
  input  logic                          alu_valid_i,
  input  logic [2*DATA_WIDTH-1:0]       alu_data_i,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [2*DATA_WIDTH-1:0]       rsp_data_o,
  output logic                          err_o
);

  // Handshake: requester k transfers on a rising edge where req_valid_i[k] && req_ready_o[k];
  // valid may drop at any time before ready without side effects. The alu side has no
  // backpressure: every alu_valid_i beat is consumed that cycle.

  localparam int IW = tag_width(NUM_REQ);

  logic [IW-1:0]           rr_ptr;
  logic [IW-1:0]           grant_idx;
  logic [IW-1:0]           tag_head;
  logic                    grant_found;
  logic                    tag_full;
  logic                    tag_empty;
  logic                    transfer;
  logic                    pop;
  logic                    err_q;
  logic [NUM_REQ-1:0]      grant;
  logic [NUM_REQ-1:0]      rsp_valid_d;
  logic [2*DATA_WIDTH-1:0] rsp_data_d;

  // First valid requester after the last winner, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!grant_found && req_valid_i[(int'(rr_ptr) + i) % NUM_REQ]) begin
        grant_found = 1'b1;
        grant_idx   = IW'((int'(rr_ptr) + i) % NUM_REQ);
      end
    end
  end

  // A full tag FIFO blocks the grant even if a result pops this same cycle.
  assign transfer = grant_found && !tag_full && !rst;

  always_comb begin
    grant = '0;
    if (transfer) grant[grant_idx] = 1'b1;
  end

  assign req_ready_o = grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr       <= IW'(NUM_REQ - 1);
      alu_valid_o  <= 1'b0;
      alu_data_1_o <= '0;
      alu_data_2_o <= '0;
      alu_sel_o    <= '0;
    end else begin
      alu_valid_o <= transfer;
      if (transfer) begin
        rr_ptr       <= grant_idx;
        alu_data_1_o <= req_data_1_i[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        alu_data_2_o <= req_data_2_i[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        alu_sel_o    <= req_sel_i[int'(grant_idx)*SEL_WIDTH +: SEL_WIDTH];
      end
    end
  end

  alu_arb_tag_fifo #(
    .WIDTH (IW),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (transfer),
    .push_data (grant_idx),
    .pop       (pop),
    .head      (tag_head),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  assign pop = alu_valid_i && !tag_empty;

  // A result with no outstanding tag is an orphan; the flag stays up until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (alu_valid_i && tag_empty) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = '0;
    if (pop) begin
      rsp_valid_d[tag_head] = 1'b1;
      rsp_data_d            = alu_data_i;
    end
  end

`ifdef ALU_ARB_RSP_REG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_o <= '0;
      rsp_data_o  <= '0;
    end else begin
      rsp_valid_o <= rsp_valid_d;
      rsp_data_o  <= rsp_data_d;
    end
  end
`else
  assign rsp_valid_o = rsp_valid_d;
  assign rsp_data_o  = rsp_data_d;
`endif

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one alu instance (2..8).
REQ-002 Parameter DATA_WIDTH, default 8, operand width; results are 2*DATA_WIDTH.
REQ-003 Parameter SEL_WIDTH, default 2, opcode width (00 add, 01 sub, 10 increment, 11 zero).
REQ-004 Parameter TAG_DEPTH, default 4, depth of the in-flight requester-ID FIFO (power of two, >=2).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 req_valid_i  in  NUM_REQ  per-requester operation request.
REQ-008 req_data_1_i, req_data_2_i  in  NUM_REQ*DATA_WIDTH each  packed operands, requester k at slice k.
REQ-009 req_sel_i  in  NUM_REQ*SEL_WIDTH  packed opcodes.
REQ-010 req_ready_o  out  NUM_REQ  one-hot grant; a transfer occurs when valid and ready are both high.
REQ-011 alu_valid_o  out  1; alu_data_1_o, alu_data_2_o  out  DATA_WIDTH; alu_sel_o  out  SEL_WIDTH  drive the alu inputs.
REQ-012 alu_valid_i  in  1; alu_data_i  in  2*DATA_WIDTH  alu result return.
REQ-013 rsp_valid_o  out  NUM_REQ  one-hot result strobe; rsp_data_o  out  2*DATA_WIDTH  shared result bus.
REQ-014 err_o  out  1  sticky orphan-result flag.

Function
REQ-015 At most one requester SHALL be granted per cycle; arbitration is round-robin, search starting at last-granted index +1, wrapping NUM_REQ-1 -> 0.
REQ-016 Grant is combinational from req_valid_i, round-robin pointer and tag-FIFO full; req_ready_o SHALL be all-zero when the tag FIFO is full.
REQ-017 On transfer from requester k: alu_valid_o=1 and alu operands/opcode = requester k slice, registered (one cycle after transfer); k pushed into tag FIFO the same edge; pointer updates to k.
REQ-018 No transfer -> alu_valid_o=0 next cycle; operand outputs hold last value.
REQ-019 Back-to-back grants SHALL be possible every cycle (full throughput) while the FIFO is not full.
REQ-020 On alu_valid_i=1: pop tag t, assert rsp_valid_o[t] for exactly that cycle, rsp_data_o=alu_data_i (combinational pass-through); results return in issue order.
REQ-021 Simultaneous push and pop SHALL both occur; occupancy unchanged; push permitted when full only if no -- full blocks grant regardless of pop that cycle.
REQ-022 alu_valid_i=1 with FIFO empty: no rsp_valid_o, no pop, err_o set and held until reset.
REQ-023 A requester deasserting valid before ready is legal; no transfer occurs.
REQ-024 Total latency transfer -> rsp_valid_o = 1 (arbiter register) + 2 (alu) = 3 cycles.

Reset
REQ-025 rst asserted: req_ready_o=0, alu_valid_o=0, operand/opcode outputs=0, rsp_valid_o=0, rsp_data_o=0, err_o=0, FIFO empty, pointer=NUM_REQ-1 (requester 0 wins first).
REQ-026 Reset mid-operation discards all in-flight tags; results returning after reset release are orphans per REQ-022 (bench must idle alu 3 cycles around reset).

Configuration
REQ-027 Macro ALU_ARB_RSP_REG_EN defined: rsp_valid_o/rsp_data_o registered, latency becomes 4, reset value 0.
REQ-028 Macro undefined: rsp outputs combinational per REQ-020; ports identical in both builds.

Structure
REQ-029 Package alu_arb_pkg: opcode constants (OP_ADD, OP_SUB, OP_INC, OP_ZERO), default widths, ALU_LATENCY=2.
REQ-030 Sub-module alu_arb_tag_fifo (synchronous FIFO, async reset, full/empty flags) holds requester IDs; arbiter logic stays in alu_arbiter.

Verification
REQ-031 After reset, req_valid_i=4'b1111, all ops add 3+4 -> grants 0,1,2,3,0 on consecutive cycles; each rsp_valid_o[k] with rsp_data_o=7 three cycles after its grant.
REQ-032 Only requester 2 valid, sub 9-5 -> ready[2] same cycle, rsp_valid_o[2], rsp_data_o=4 three cycles later; no other strobes.
REQ-033 Stall alu returns (tie alu_valid_i=0) with continuous requests -> exactly TAG_DEPTH=4 grants then req_ready_o=0 until a result returns.
REQ-034 Inject alu_valid_i=1 with FIFO empty -> err_o=1 and stays 1; no rsp_valid_o; cleared only by rst.
REQ-035 Assert rst with 2 ops in flight -> all outputs 0 within the reset cycle; first grant after release goes to requester 0.
REQ-036 Build with ALU_ARB_RSP_REG_EN, rerun REQ-031 -> identical data, latency 4 cycles.
